// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample type and serial-format constants
package audio_pkg;

  localparam int AUDIO_WS      = 16;
  typedef logic signed [AUDIO_WS-1:0] audio_t;

  localparam int SLOT_BITS_DEF = 32;
  localparam int BCLK_HALF_DEF = 8;

  localparam bit FMT_I2S       = 1'b1;
  localparam bit FMT_LJ        = 1'b0;

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK/LRCK divider with bit counter and fall/load strobes
module i2s_clkgen #(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 8,
  localparam int BIT_W    = $clog2(2*SLOT_BITS)
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic             iEN,
  output logic             oBCLK,
  output logic             oLRCK,
  output logic [BIT_W-1:0] oBitNext,
  output logic             oFall,
  output logic             oLoad
);

  localparam int DIV_W = $clog2(BCLK_HALF);

  logic [DIV_W-1:0] divCnt;
  logic [BIT_W-1:0] bitCnt;
  logic             divTerm;

  assign divTerm  = (divCnt == DIV_W'(BCLK_HALF-1));
  // oFall marks the cycle whose closing edge drops BCLK and advances the bit
  assign oFall    = iEN & divTerm & oBCLK;
  assign oBitNext = (bitCnt == BIT_W'(2*SLOT_BITS-1)) ? '0 : bitCnt + 1'b1;
  assign oLoad    = iEN & ~iRST & ~oBCLK & (divCnt == '0) & (bitCnt == '0);

  always_ff @(posedge iCLK_50) begin
    if (iRST || !iEN) begin
      divCnt <= '0;
      bitCnt <= '0;
      oBCLK  <= 1'b0;
      oLRCK  <= 1'b0;
    end else begin
      divCnt <= divTerm ? '0 : divCnt + 1'b1;
      if (divTerm) oBCLK <= ~oBCLK;
      if (oFall) begin
        bitCnt <= oBitNext;
        oLRCK  <= (oBitNext >= BIT_W'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - clock-master stereo I2S / left-justified serial transmitter
module i2s_master_tx
  import audio_pkg::*;
#(
  parameter int AUDIO_WS  = audio_pkg::AUDIO_WS,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter bit I2S_MODE  = FMT_I2S
) (
  input  logic                iCLK_50,
  input  logic                iRST,
  input  logic                iEN,
  input  logic [AUDIO_WS-1:0] iL,
  input  logic [AUDIO_WS-1:0] iR,
  input  logic                iVALID,
  output logic                oREADY,
  output logic                oBCLK,
  output logic                oLRCK,
  output logic                oDAT,
  output logic                oFRAME,
  output logic                oUNDERRUN
);

  localparam int BIT_W = $clog2(2*SLOT_BITS);

  logic [BIT_W-1:0]    bitNext;
  logic                fall, load;
  logic                holdFull, holdFullNext, accept;
  logic [AUDIO_WS-1:0] holdL, holdR, shadowL, shadowR;
  logic                nextRight, fallDat, loadDat;
  int                  nextPos;

  i2s_clkgen #(
    .SLOT_BITS(SLOT_BITS),
    .BCLK_HALF(BCLK_HALF)
  ) uClkgen (
    .iCLK_50 (iCLK_50),
    .iRST    (iRST),
    .iEN     (iEN),
    .oBCLK   (oBCLK),
    .oLRCK   (oLRCK),
    .oBitNext(bitNext),
    .oFall   (fall),
    .oLoad   (load)
  );

  // Slot bit at position pos: MSB sits I2S_MODE bits into the slot, padding is zero
  function automatic logic slotBit(input logic [AUDIO_WS-1:0] word, input int pos);
    int                  q;
    logic [AUDIO_WS-1:0] sh;
    slotBit = 1'b0;
    q = pos - int'(I2S_MODE);
    if (q >= 0 && q < AUDIO_WS) begin
      sh      = word >> (AUDIO_WS-1-q);
      slotBit = sh[0];
    end
  endfunction

  always_comb begin
    nextRight    = (bitNext >= BIT_W'(SLOT_BITS));
    nextPos      = int'(bitNext) - (nextRight ? SLOT_BITS : 0);
    fallDat      = slotBit(nextRight ? shadowR : shadowL, nextPos);
    loadDat      = slotBit(holdFull ? holdL : shadowL, 0);
    accept       = iVALID & oREADY;
    holdFullNext = holdFull;
    if (load && holdFull) holdFullNext = 1'b0;
    if (accept)           holdFullNext = 1'b1;
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      holdFull <= 1'b0;
      holdL    <= '0;
      holdR    <= '0;
      shadowL  <= '0;
      shadowR  <= '0;
      oDAT     <= 1'b0;
      oREADY   <= 1'b1;
    end else begin
      holdFull <= holdFullNext;
      oREADY   <= ~holdFullNext;
      if (accept) begin
        holdL <= iL;
        holdR <= iR;
      end
      if (load && holdFull) begin
        shadowL <= holdL;
        shadowR <= holdR;
      end
      if (!iEN)      oDAT <= 1'b0;
      else if (load) oDAT <= loadDat;
      else if (fall) oDAT <= fallDat;
    end
  end

  assign oFRAME    = load;
  assign oUNDERRUN = load & ~holdFull;

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb/tb_i2s_master_tx.sv - randomized bench for i2s_master_tx in I2S and left-justified modes
module tb_i2s_master_tx;
  import audio_pkg::*;

  localparam int H     = 2;
  localparam int SLOT  = 32;
  localparam int WS    = 16;
  localparam int FRAME = 2*SLOT*2*H;

  logic        iCLK_50 = 1'b0;
  logic        iRST    = 1'b1;
  logic        iEN     = 1'b0;
  logic        iVALID  = 1'b0;
  logic [15:0] iL      = '0;
  logic [15:0] iR      = '0;

  logic readyA, bclkA, lrckA, datA, frameA, underA;
  logic readyB, bclkB, lrckB, datB, frameB, underB;

  int     nChecks = 0;
  int     nErrors = 0;
  int     c;
  logic   mFull;
  audio_t mHoldL, mHoldR, mShL, mShR;
  logic   waitOk;

  i2s_master_tx #(.AUDIO_WS(WS), .SLOT_BITS(SLOT), .BCLK_HALF(H), .I2S_MODE(1'b1)) dutI2s (
    .iCLK_50(iCLK_50), .iRST(iRST), .iEN(iEN), .iL(iL), .iR(iR), .iVALID(iVALID),
    .oREADY(readyA), .oBCLK(bclkA), .oLRCK(lrckA), .oDAT(datA), .oFRAME(frameA), .oUNDERRUN(underA)
  );

  i2s_master_tx #(.AUDIO_WS(WS), .SLOT_BITS(SLOT), .BCLK_HALF(H), .I2S_MODE(1'b0)) dutLj (
    .iCLK_50(iCLK_50), .iRST(iRST), .iEN(iEN), .iL(iL), .iR(iR), .iVALID(iVALID),
    .oREADY(readyB), .oBCLK(bclkB), .oLRCK(lrckB), .oDAT(datB), .oFRAME(frameB), .oUNDERRUN(underB)
  );

  always #10 iCLK_50 = ~iCLK_50;

  task automatic checkVal(input string tag, input logic got, input logic exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %b, expected %b at t=%0t (c=%0d)", tag, got, exp, $time, c);
    end
  endtask

  // Slot image: word left-aligned in the slot, shifted right by the format delay
  function automatic logic refBit(input logic [15:0] w, input int p, input int mode);
    logic [SLOT-1:0] img;
    logic [SLOT-1:0] sh;
    img = {w, {(SLOT-WS){1'b0}}} >> mode;
    sh  = img >> (SLOT-1-p);
    return sh[0];
  endfunction

  task automatic doChecks();
    int          b;
    logic [15:0] w;
    logic        expBclk, expLrck, expFrame, expUnder;
    b        = (c / (2*H)) % (2*SLOT);
    w        = (b < SLOT) ? mShL : mShR;
    expBclk  = (c % (2*H)) >= H;
    expLrck  = b >= SLOT;
    expFrame = iEN && !iRST && (c % FRAME == 0);
    expUnder = expFrame && !mFull;
    checkVal("readyI2s", readyA, !mFull);
    checkVal("readyLj",  readyB, !mFull);
    checkVal("bclkI2s",  bclkA,  expBclk);
    checkVal("bclkLj",   bclkB,  expBclk);
    checkVal("lrckI2s",  lrckA,  expLrck);
    checkVal("lrckLj",   lrckB,  expLrck);
    checkVal("frameI2s", frameA, expFrame);
    checkVal("frameLj",  frameB, expFrame);
    checkVal("underI2s", underA, expUnder);
    checkVal("underLj",  underB, expUnder);
    if (c % FRAME != 0) begin
      checkVal("datI2s", datA, refBit(w, b % SLOT, 1));
      checkVal("datLj",  datB, refBit(w, b % SLOT, 0));
    end else if (!iEN || iRST) begin
      checkVal("datI2sIdle", datA, 1'b0);
      checkVal("datLjIdle",  datB, 1'b0);
    end
  endtask

  task automatic modelEdge();
    logic isLoad, acc;
    if (iRST) begin
      c      = 0;
      mFull  = 1'b0;
      mHoldL = '0;
      mHoldR = '0;
      mShL   = '0;
      mShR   = '0;
    end else begin
      isLoad = iEN && (c % FRAME == 0);
      acc    = iVALID && !mFull;
      if (isLoad && mFull) begin
        mShL  = mHoldL;
        mShR  = mHoldR;
        mFull = 1'b0;
      end
      if (acc) begin
        mHoldL = iL;
        mHoldR = iR;
        mFull  = 1'b1;
      end
      c = iEN ? (c + 1) % FRAME : 0;
    end
  endtask

  task automatic tick();
    @(negedge iCLK_50);
    doChecks();
    @(posedge iCLK_50);
    modelEdge();
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    iL     = l;
    iR     = r;
    iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
  endtask

  initial begin
    @(posedge iCLK_50);
    modelEdge();
    #1;
    repeat (3) tick();

    // first enabled cycle loads an empty holding register
    iRST = 1'b0;
    iEN  = 1'b1;
    tick();
    iEN = 1'b0;
    repeat (2) tick();

    push(16'h8001, 16'h7FFE);
    iEN = 1'b1;
    repeat (2*FRAME) tick();

    // holding full: a held iVALID is ignored until the load frees the register
    repeat (40) tick();
    push(16'hC000, 16'h0003);
    iL     = 16'h1234;
    iR     = 16'hABCD;
    iVALID = 1'b1;
    waitOk = 1'b0;
    for (int k = 0; k < 2*FRAME; k++) begin
      if (mFull && mHoldL == 16'h1234) begin
        waitOk = 1'b1;
        break;
      end
      tick();
    end
    checkVal("acceptWait", waitOk, 1'b1);
    iVALID = 1'b0;
    repeat (2*FRAME) tick();

    // accept offered on the load cycle itself
    waitOk = 1'b0;
    for (int k = 0; k < 2*FRAME; k++) begin
      if (c % FRAME == 0 && !mFull) begin
        waitOk = 1'b1;
        break;
      end
      tick();
    end
    checkVal("loadWait", waitOk, 1'b1);
    push(16'($urandom), 16'($urandom));
    repeat (2*FRAME) tick();

    for (int k = 0; k < 6*FRAME; k++) begin
      iL     = 16'($urandom);
      iR     = 16'($urandom);
      iVALID = ($urandom_range(0, 29) == 0);
      iEN    = ($urandom_range(0, 499) != 0);
      tick();
    end
    iVALID = 1'b0;
    iEN    = 1'b1;

    // reset in the middle of left-slot bit 20
    waitOk = 1'b0;
    for (int k = 0; k < 2*FRAME; k++) begin
      if (c == 20*2*H + 1) begin
        waitOk = 1'b1;
        break;
      end
      tick();
    end
    checkVal("bitWait", waitOk, 1'b1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    iEN  = 1'b0;
    repeat (2) tick();
    iEN = 1'b1;
    push(16'h5A5A, 16'hA5A5);
    repeat (FRAME + 8) tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
